// File: rtl/bus_width_adapter_pkg.sv
// Shared helpers and state encodings for the bus width adapter.
package bus_width_adapter_pkg;

    // Number of narrow slices per wide word.
    function automatic int unsigned ratio_f(input int unsigned in_w, input int unsigned out_w);
        if (in_w == 0 || out_w == 0) begin
            return 1;
        end
        return (in_w > out_w) ? (in_w / out_w) : (out_w / in_w);
    endfunction

    // Slice counter width, never narrower than one bit.
    function automatic int unsigned cnt_w_f(input int unsigned ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

    typedef enum logic {ST_FILL, ST_FULL} up_state_e;
    typedef enum logic {ST_IDLE, ST_SEND} dn_state_e;

endpackage

// File: rtl/bus_width_adapter_slice_cnt.sv
// Slice counter with synchronous clear, increment and terminal-count flag.
module bus_width_adapter_slice_cnt
    import bus_width_adapter_pkg::*;
#(
    parameter int unsigned RATIO = 4,
    parameter int unsigned CNT_W = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_last
);

    logic [CNT_W-1:0] r_cnt;

    // Clear has priority so a reload and a final increment resolve to slice 0.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_last = (r_cnt == CNT_W'(RATIO - 1));

endmodule

// File: rtl/bus_width_adapter.sv
// Valid/ready bus width adapter: packs (upsize), serialises (downsize) or registers (equal).
// Optional feature macro: BUS_WIDTH_ADAPTER_LAST_EN adds in_last, out_last and out_keep.
module bus_width_adapter
    import bus_width_adapter_pkg::*;
#(
    parameter int unsigned IN_WIDTH  = 8,
    parameter int unsigned OUT_WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready
`ifdef BUS_WIDTH_ADAPTER_LAST_EN
    ,
    input  logic                 in_last,
    output logic                 out_last,
    output logic [(IN_WIDTH < OUT_WIDTH ? ratio_f(IN_WIDTH, OUT_WIDTH) : 1)-1:0] out_keep
`endif
);

    localparam int unsigned RATIO = ratio_f(IN_WIDTH, OUT_WIDTH);

    if (IN_WIDTH < 1 || IN_WIDTH > 64 || OUT_WIDTH < 1 || OUT_WIDTH > 64) begin : g_bad_width
        $error("bus_width_adapter: widths must be within 1..64");
    end
    if (RATIO * ((IN_WIDTH < OUT_WIDTH) ? IN_WIDTH : OUT_WIDTH)
        != ((IN_WIDTH > OUT_WIDTH) ? IN_WIDTH : OUT_WIDTH)) begin : g_bad_ratio
        $error("bus_width_adapter: larger width must be a multiple of the smaller");
    end

    if (IN_WIDTH < OUT_WIDTH) begin : g_up
        localparam int unsigned CNT_W = cnt_w_f(RATIO);
        up_state_e            r_state;
        up_state_e            w_state_next;
        logic [OUT_WIDTH-1:0] r_acc;
        logic [OUT_WIDTH-1:0] w_acc_next;
        logic [OUT_WIDTH-1:0] r_out_data;
        logic                 r_out_valid;
        logic [CNT_W-1:0]     w_cnt;
        logic                 w_cnt_last;
        logic                 w_in_last;
        logic                 w_accept;
        logic                 w_xfer;
        logic                 w_close;

`ifdef BUS_WIDTH_ADAPTER_LAST_EN
        logic [RATIO-1:0] r_keep;
        logic [RATIO-1:0] w_keep_next;
        logic             r_last;
        assign w_in_last = in_last;
`else
        assign w_in_last = 1'b0;
`endif

        assign in_ready  = reset_n && ((r_state == ST_FILL) || out_ready);
        assign w_accept  = in_valid && in_ready;
        assign w_xfer    = r_out_valid && out_ready;
        assign w_close   = w_accept && (w_cnt_last || w_in_last);
        assign out_data  = r_out_data;
        assign out_valid = r_out_valid;

        bus_width_adapter_slice_cnt #(
            .RATIO (RATIO),
            .CNT_W (CNT_W)
        ) u_cnt (
            .clock   (clock),
            .reset_n (reset_n),
            .i_clr   (w_close),
            .i_inc   (w_accept),
            .o_cnt   (w_cnt),
            .o_last  (w_cnt_last)
        );

        // State register.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                r_state <= ST_FILL;
            end else begin
                r_state <= w_state_next;
            end
        end

        // A closing accept always lands in FULL, even if the old word drains this cycle.
        always_comb begin
            w_state_next = r_state;
            if (w_close) begin
                w_state_next = ST_FULL;
            end else if (w_xfer) begin
                w_state_next = ST_FILL;
            end
        end

        // Accumulator with the incoming slice merged in.
        always_comb begin
            w_acc_next = r_acc;
            w_acc_next[int'(w_cnt) * IN_WIDTH +: IN_WIDTH] = in_data;
        end

        // Accumulator is zeroed on close so an early-closed word has empty upper slices.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                r_acc       <= '0;
                r_out_data  <= '0;
                r_out_valid <= 1'b0;
            end else begin
                if (w_accept) begin
                    r_acc <= w_close ? '0 : w_acc_next;
                end
                if (w_close) begin
                    r_out_data  <= w_acc_next;
                    r_out_valid <= 1'b1;
                end else if (w_xfer) begin
                    r_out_valid <= 1'b0;
                end
            end
        end

`ifdef BUS_WIDTH_ADAPTER_LAST_EN
        // Keep marks every slice up to and including the closing one.
        always_comb begin
            w_keep_next = '0;
            for (int i = 0; i < RATIO; i++) begin
                w_keep_next[i] = (i <= int'(w_cnt));
            end
        end

        // Sideband registered alongside the output word.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                r_keep <= '0;
                r_last <= 1'b0;
            end else if (w_close) begin
                r_keep <= w_keep_next;
                r_last <= w_in_last;
            end
        end

        assign out_keep = r_keep;
        assign out_last = r_last;
`endif
    end else if (IN_WIDTH > OUT_WIDTH) begin : g_down
        localparam int unsigned CNT_W = cnt_w_f(RATIO);
        dn_state_e           r_state;
        dn_state_e           w_state_next;
        logic [IN_WIDTH-1:0] r_hold;
        logic                r_out_valid;
        logic [CNT_W-1:0]    w_cnt;
        logic                w_cnt_last;
        logic                w_in_last;
        logic                w_accept;
        logic                w_xfer;

`ifdef BUS_WIDTH_ADAPTER_LAST_EN
        logic r_last_word;
        assign w_in_last = in_last;
`else
        assign w_in_last = 1'b0;
`endif

        // A new word is only taken as the final slice of the current one leaves.
        assign in_ready  = reset_n && ((r_state == ST_IDLE) || (out_ready && w_cnt_last));
        assign w_accept  = in_valid && in_ready;
        assign w_xfer    = r_out_valid && out_ready;
        assign out_data  = r_hold[int'(w_cnt) * OUT_WIDTH +: OUT_WIDTH];
        assign out_valid = r_out_valid;

        bus_width_adapter_slice_cnt #(
            .RATIO (RATIO),
            .CNT_W (CNT_W)
        ) u_cnt (
            .clock   (clock),
            .reset_n (reset_n),
            .i_clr   (w_accept || (w_xfer && w_cnt_last)),
            .i_inc   (w_xfer),
            .o_cnt   (w_cnt),
            .o_last  (w_cnt_last)
        );

        // State register.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                r_state <= ST_IDLE;
            end else begin
                r_state <= w_state_next;
            end
        end

        // Reload beats return-to-idle so back-to-back words have no bubble.
        always_comb begin
            w_state_next = r_state;
            if (w_accept) begin
                w_state_next = ST_SEND;
            end else if (w_xfer && w_cnt_last) begin
                w_state_next = ST_IDLE;
            end
        end

        // Hold register and output valid.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                r_hold      <= '0;
                r_out_valid <= 1'b0;
            end else if (w_accept) begin
                r_hold      <= in_data;
                r_out_valid <= 1'b1;
            end else if (w_xfer && w_cnt_last) begin
                r_out_valid <= 1'b0;
            end
        end

`ifdef BUS_WIDTH_ADAPTER_LAST_EN
        // Remember whether the held word ends a packet.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                r_last_word <= 1'b0;
            end else if (w_accept) begin
                r_last_word <= w_in_last;
            end
        end

        assign out_last = r_out_valid && w_cnt_last && r_last_word;
        assign out_keep = r_out_valid;
`endif
    end else begin : g_eq
        logic [OUT_WIDTH-1:0] r_data;
        logic                 r_valid;
        logic                 w_accept;

        assign in_ready  = reset_n && (!r_valid || out_ready);
        assign w_accept  = in_valid && in_ready;
        assign out_data  = r_data;
        assign out_valid = r_valid;

        // One-deep pipeline register.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                r_data  <= '0;
                r_valid <= 1'b0;
            end else if (w_accept) begin
                r_data  <= in_data;
                r_valid <= 1'b1;
            end else if (out_ready) begin
                r_valid <= 1'b0;
            end
        end

`ifdef BUS_WIDTH_ADAPTER_LAST_EN
        logic r_last;

        // Last flag travels with the data word.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                r_last <= 1'b0;
            end else if (w_accept) begin
                r_last <= in_last;
            end
        end

        assign out_last = r_last;
        assign out_keep = r_valid;
`endif
    end

endmodule

// File: tb/tb_bus_width_adapter.sv
// Self-checking bench for bus_width_adapter in 8->32, 32->8 and 16->16 configurations.
`timescale 1ns/1ps
module tb_bus_width_adapter;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]  u_in_data  = '0;
    logic        u_in_valid = 1'b0;
    logic        u_in_ready;
    logic [31:0] u_out_data;
    logic        u_out_valid;
    logic        u_out_ready = 1'b0;

    logic [31:0] d_in_data  = '0;
    logic        d_in_valid = 1'b0;
    logic        d_in_ready;
    logic [7:0]  d_out_data;
    logic        d_out_valid;
    logic        d_out_ready = 1'b0;

    logic [15:0] e_in_data  = '0;
    logic        e_in_valid = 1'b0;
    logic        e_in_ready;
    logic [15:0] e_out_data;
    logic        e_out_valid;
    logic        e_out_ready = 1'b0;

    logic [7:0]  u_src[$];
    logic [31:0] u_exp[$];
    logic [31:0] d_src[$];
    logic [7:0]  d_exp[$];
    logic [15:0] e_src[$];
    logic [15:0] e_exp[$];

`ifdef BUS_WIDTH_ADAPTER_LAST_EN
    logic       u_in_last = 1'b0;
    logic       u_out_last;
    logic [3:0] u_out_keep;
    logic       d_in_last = 1'b0;
    logic       d_out_last;
    logic [0:0] d_out_keep;
    logic       e_in_last = 1'b0;
    logic       e_out_last;
    logic [0:0] e_out_keep;
`endif

    bus_width_adapter #(.IN_WIDTH(8), .OUT_WIDTH(32)) u_dut_up (
        .clock     (clk),
        .reset_n   (rst_n),
        .in_data   (u_in_data),
        .in_valid  (u_in_valid),
        .in_ready  (u_in_ready),
        .out_data  (u_out_data),
        .out_valid (u_out_valid),
        .out_ready (u_out_ready)
`ifdef BUS_WIDTH_ADAPTER_LAST_EN
        ,
        .in_last   (u_in_last),
        .out_last  (u_out_last),
        .out_keep  (u_out_keep)
`endif
    );

    bus_width_adapter #(.IN_WIDTH(32), .OUT_WIDTH(8)) u_dut_dn (
        .clock     (clk),
        .reset_n   (rst_n),
        .in_data   (d_in_data),
        .in_valid  (d_in_valid),
        .in_ready  (d_in_ready),
        .out_data  (d_out_data),
        .out_valid (d_out_valid),
        .out_ready (d_out_ready)
`ifdef BUS_WIDTH_ADAPTER_LAST_EN
        ,
        .in_last   (d_in_last),
        .out_last  (d_out_last),
        .out_keep  (d_out_keep)
`endif
    );

    bus_width_adapter #(.IN_WIDTH(16), .OUT_WIDTH(16)) u_dut_eq (
        .clock     (clk),
        .reset_n   (rst_n),
        .in_data   (e_in_data),
        .in_valid  (e_in_valid),
        .in_ready  (e_in_ready),
        .out_data  (e_out_data),
        .out_valid (e_out_valid),
        .out_ready (e_out_ready)
`ifdef BUS_WIDTH_ADAPTER_LAST_EN
        ,
        .in_last   (e_in_last),
        .out_last  (e_out_last),
        .out_keep  (e_out_keep)
`endif
    );

    // Upsize stream runner: scoreboard compare on every output transfer.
    task automatic run_up(input int budget, input bit rnd);
        int cyc = 0;
        logic [31:0] exp_w;
        while ((u_src.size() > 0 || u_exp.size() > 0) && cyc < budget) begin
            u_in_valid = (u_src.size() > 0) && (!rnd || ($urandom_range(0, 1) == 1));
            if (u_src.size() > 0) u_in_data = u_src[0];
            u_out_ready = !rnd || ($urandom_range(0, 1) == 1);
            @(negedge clk);
            if (u_out_valid && u_out_ready) begin
                n_vec++;
                if (u_exp.size() == 0) begin
                    n_err++;
                    $display("FAIL up_extra_word: got %h, none expected", u_out_data);
                end else begin
                    exp_w = u_exp.pop_front();
                    if (u_out_data !== exp_w) begin
                        n_err++;
                        $display("FAIL up_word: got %h want %h", u_out_data, exp_w);
                    end
                end
            end
            if (u_in_valid && u_in_ready) void'(u_src.pop_front());
            @(posedge clk);
            #1;
            cyc++;
        end
        u_in_valid = 1'b0;
        if (cyc >= budget) begin
            n_vec++;
            n_err++;
            $display("FAIL up_timeout: %0d src %0d exp left", u_src.size(), u_exp.size());
            u_src.delete();
            u_exp.delete();
        end
    endtask

    // Downsize runner: reference model of valid/ready plus held-slice scoreboard.
    // mode 0: out_ready=1, mode 1: pattern 1,0,0, mode 2: random.
    task automatic run_down(input int budget, input int mode);
        int cyc = 0;
        bit busy = 1'b0;
        int cnt = 0;
        bit exp_rdy;
        bit acc;
        bit xfer;
        while ((d_src.size() > 0 || d_exp.size() > 0) && cyc < budget) begin
            d_in_valid = (d_src.size() > 0);
            if (d_src.size() > 0) d_in_data = d_src[0];
            if (mode == 0) d_out_ready = 1'b1;
            else if (mode == 1) d_out_ready = (cyc % 3 == 0);
            else d_out_ready = ($urandom_range(0, 1) == 1);
            @(negedge clk);
            exp_rdy = !busy || (d_out_ready && cnt == 3);
            n_vec++;
            if (d_in_ready !== exp_rdy) begin
                n_err++;
                $display("FAIL dn_in_ready: got %b want %b (cycle %0d)", d_in_ready, exp_rdy, cyc);
            end
            n_vec++;
            if (d_out_valid !== busy) begin
                n_err++;
                $display("FAIL dn_out_valid: got %b want %b (cycle %0d)", d_out_valid, busy, cyc);
            end
            if (busy) begin
                n_vec++;
                if (d_exp.size() == 0) begin
                    n_err++;
                    $display("FAIL dn_extra_slice: got %h", d_out_data);
                end else if (d_out_data !== d_exp[0]) begin
                    n_err++;
                    $display("FAIL dn_slice: got %h want %h", d_out_data, d_exp[0]);
                end
            end
            acc  = d_in_valid && exp_rdy;
            xfer = busy && d_out_ready;
            if (xfer && d_exp.size() > 0) void'(d_exp.pop_front());
            if (acc) begin
                void'(d_src.pop_front());
                busy = 1'b1;
                cnt  = 0;
            end else if (xfer) begin
                if (cnt == 3) busy = 1'b0;
                else cnt++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        d_in_valid = 1'b0;
        if (cyc >= budget) begin
            n_vec++;
            n_err++;
            $display("FAIL dn_timeout: %0d src %0d exp left", d_src.size(), d_exp.size());
            d_src.delete();
            d_exp.delete();
        end
    endtask

    task automatic push_down_word(input logic [31:0] w);
        d_src.push_back(w);
        for (int i = 0; i < 4; i++) d_exp.push_back(w[i*8 +: 8]);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({u_in_ready, u_out_valid, u_out_data} !== 34'h0) begin
            n_err++;
            $display("FAIL reset_up: rdy %b vld %b data %h want 0", u_in_ready, u_out_valid,
                     u_out_data);
        end
        n_vec++;
        if ({d_in_ready, d_out_valid, d_out_data} !== 10'h0) begin
            n_err++;
            $display("FAIL reset_dn: rdy %b vld %b data %h want 0", d_in_ready, d_out_valid,
                     d_out_data);
        end
        n_vec++;
        if ({e_in_ready, e_out_valid, e_out_data} !== 18'h0) begin
            n_err++;
            $display("FAIL reset_eq: rdy %b vld %b data %h want 0", e_in_ready, e_out_valid,
                     e_out_data);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({u_in_ready, d_in_ready, e_in_ready} !== 3'b111) begin
            n_err++;
            $display("FAIL release_ready: got %b%b%b want 111", u_in_ready, d_in_ready,
                     e_in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_upsize;
        logic [31:0] exp_w;
        u_out_ready = 1'b1;
        u_exp.push_back(32'h44332211);
        for (int i = 0; i < 4; i++) begin
            u_in_valid = 1'b1;
            u_in_data  = 8'((i + 1) * 17);
            @(negedge clk);
            n_vec++;
            if (u_in_ready !== 1'b1 || u_out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL up_fill_%0d: rdy %b vld %b want 1 0", i, u_in_ready, u_out_valid);
            end
            @(posedge clk);
            #1;
        end
        u_in_valid = 1'b0;
        @(negedge clk);
        n_vec++;
        if (u_out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL up_latency: out_valid %b want 1", u_out_valid);
        end else begin
            exp_w = u_exp.pop_front();
            n_vec++;
            if (u_out_data !== exp_w) begin
                n_err++;
                $display("FAIL up_word: got %h want %h", u_out_data, exp_w);
            end
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        n_vec++;
        if (u_out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL up_drain: out_valid %b want 0", u_out_valid);
        end
        u_exp.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic test_downsize_back_to_back;
        push_down_word(32'hA1B2C3D4);
        push_down_word(32'h01020304);
        run_down(40, 0);
    endtask

    task automatic test_downsize_backpressure;
        push_down_word(32'h11223344);
        push_down_word(32'h55667788);
        push_down_word(32'h99AABBCC);
        run_down(120, 1);
    endtask

    task automatic test_reset_mid;
        u_out_ready = 1'b1;
        u_in_valid  = 1'b1;
        u_in_data   = 8'hAA;
        @(posedge clk);
        #1;
        u_in_data = 8'hBB;
        @(posedge clk);
        #1;
        u_in_valid = 1'b0;
        rst_n      = 1'b0;
        @(negedge clk);
        n_vec++;
        if (u_out_valid !== 1'b0 || u_in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset: vld %b rdy %b want 0 0", u_out_valid, u_in_ready);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 1; i <= 4; i++) u_src.push_back(8'(i));
        u_exp.push_back(32'h04030201);
        run_up(40, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++;
            if (u_out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL mid_reset_extra: out_valid %b want 0", u_out_valid);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_upsize_random;
        logic [31:0] w;
        for (int n = 0; n < 12; n++) begin
            w = $urandom;
            for (int i = 0; i < 4; i++) u_src.push_back(w[i*8 +: 8]);
            u_exp.push_back(w);
        end
        run_up(800, 1'b1);
    endtask

    task automatic test_downsize_random;
        for (int n = 0; n < 12; n++) push_down_word($urandom);
        run_down(800, 2);
    endtask

    task automatic test_equal_random;
        int  cyc = 0;
        bit  full = 1'b0;
        bit  exp_rdy;
        bit  acc;
        bit  xfer;
        logic [15:0] w;
        for (int n = 0; n < 1000; n++) begin
            w = 16'($urandom);
            e_src.push_back(w);
            e_exp.push_back(w);
        end
        while ((e_src.size() > 0 || e_exp.size() > 0) && cyc < 20000) begin
            e_in_valid  = (e_src.size() > 0) && ($urandom_range(0, 1) == 1);
            if (e_src.size() > 0) e_in_data = e_src[0];
            e_out_ready = ($urandom_range(0, 1) == 1);
            @(negedge clk);
            exp_rdy = !full || e_out_ready;
            n_vec++;
            if (e_in_ready !== exp_rdy) begin
                n_err++;
                $display("FAIL eq_in_ready: got %b want %b (cycle %0d)", e_in_ready, exp_rdy, cyc);
            end
            n_vec++;
            if (e_out_valid !== full) begin
                n_err++;
                $display("FAIL eq_out_valid: got %b want %b (cycle %0d)", e_out_valid, full, cyc);
            end
            if (full) begin
                n_vec++;
                if (e_exp.size() == 0 || e_out_data !== e_exp[0]) begin
                    n_err++;
                    $display("FAIL eq_data: got %h want %h", e_out_data,
                             (e_exp.size() > 0) ? e_exp[0] : 16'h0);
                end
            end
            acc  = e_in_valid && exp_rdy;
            xfer = full && e_out_ready;
            if (xfer && e_exp.size() > 0) void'(e_exp.pop_front());
            if (acc) void'(e_src.pop_front());
            full = acc ? 1'b1 : (xfer ? 1'b0 : full);
            @(posedge clk);
            #1;
            cyc++;
        end
        e_in_valid = 1'b0;
        if (cyc >= 20000) begin
            n_vec++;
            n_err++;
            $display("FAIL eq_timeout: %0d src %0d exp left", e_src.size(), e_exp.size());
        end
    endtask

`ifdef BUS_WIDTH_ADAPTER_LAST_EN
    task automatic test_last;
        logic [7:0] bytes_q[3];
        bytes_q[0] = 8'h11;
        bytes_q[1] = 8'h22;
        bytes_q[2] = 8'h33;
        u_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            u_in_valid = 1'b1;
            u_in_data  = bytes_q[i];
            u_in_last  = (i == 2);
            @(posedge clk);
            #1;
        end
        u_in_valid = 1'b0;
        u_in_last  = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({u_out_valid, u_out_data, u_out_keep, u_out_last} !== {1'b1, 32'h00332211, 4'b0111,
                                                                   1'b1}) begin
            n_err++;
            $display("FAIL last_up: vld %b data %h keep %b last %b want 1 00332211 0111 1",
                     u_out_valid, u_out_data, u_out_keep, u_out_last);
        end
        u_out_ready = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 1; i <= 4; i++) u_src.push_back(8'(i + 4));
        u_exp.push_back(32'h08070605);
        run_up(40, 1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_upsize();
        test_downsize_back_to_back();
        test_downsize_backpressure();
        test_reset_mid();
        test_upsize_random();
        test_downsize_random();
        test_equal_random();
`ifdef BUS_WIDTH_ADAPTER_LAST_EN
        test_last();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bus_width_adapter.md
Name: bus_width_adapter

Overview:
Clocked successor to the static bus connector. It joins two digital buses of different widths with valid/ready handshakes on both sides.
- Upsizing (IN_WIDTH < OUT_WIDTH): packs RATIO narrow words into one wide word.
- Downsizing (IN_WIDTH > OUT_WIDTH): serialises one wide word into RATIO narrow words.
- Equal widths: behaves as a single-register pipeline stage.
- Sits between UDB datapaths and DMA/CPU-facing streams.

Parameters:
IN_WIDTH, 8, input bus width in bits (1..64).
OUT_WIDTH, 32, output bus width in bits (1..64).
RATIO (localparam), max(IN,OUT)/min(IN,OUT). The larger width must be an exact integer multiple of the smaller; otherwise elaboration fails with $error.

Ports:
clock  input  1  single system clock; all state changes on its rising edge.
reset_n  input  1  asynchronous, active-low reset.
in_data  input  IN_WIDTH  input word.
in_valid  input  1  in_data is valid.
in_ready  output  1  adapter accepts in_data this cycle.
out_data  output  OUT_WIDTH  output word.
out_valid  output  1  out_data is valid.
out_ready  input  1  sink accepts out_data this cycle.

Behaviour:
- Interface timing: single clock `clock`; reset `reset_n` is asynchronous and active-low.
- Handshake rules:
  - A transfer occurs when valid && ready are both high at a clock edge.
  - out_valid and out_data are registered outputs. Once asserted, they hold stable until taken.
  - in_ready is combinational from internal state and out_ready only; it never depends on in_valid.
- Reset values: out_valid=0, out_data=0, slice counter cnt=0, hold/accumulator register=0. in_ready=0 while reset_n is low and 1 in the first cycle after release.
- Upsize mode (two states, FILL and FULL):
  - FILL: in_ready=1. Each accepted word is written to acc[cnt*IN_WIDTH +: IN_WIDTH], with cnt incrementing. Slice 0 is the LSB.
  - Accept at cnt==RATIO-1: out_data<=acc including the new slice, out_valid<=1, cnt<=0, move to FULL.
  - FULL: in_ready=out_ready. In one cycle, an output transfer plus an input accept drains the word and writes slice 0 of the next. Output transfer with no input accept returns to FILL.
  - Latency: out_valid rises 1 cycle after the final slice is accepted.
- Downsize mode (IDLE and SEND):
  - IDLE: in_ready=1. An accept loads hold<=in_data, cnt<=0, out_valid<=1, and moves to SEND.
  - SEND: out_data=hold[cnt*OUT_WIDTH +: OUT_WIDTH], slices emitted LSB first. Each output transfer increments cnt.
  - in_ready = out_ready && cnt==RATIO-1. A simultaneous last-slice transfer and new accept reloads with no bubble. Otherwise, the last-slice transfer returns to IDLE with out_valid=0.
  - Latency: first slice appears 1 cycle after the accept.
- Equal widths (RATIO=1): one-deep register; in_ready = !out_valid || out_ready.
- Backpressure: out_ready low holds out_data and out_valid indefinitely; no data is lost or duplicated.
- Reset mid-operation: a partial word or unsent slices are discarded; all state returns to reset values immediately.
- cnt is $clog2(RATIO) bits wide, minimum 1, and wraps only through the explicit loads above.

Optional Feature:
Macro BUS_WIDTH_ADAPTER_LAST_EN.
- When defined, adds three ports:
  - in_last (input, 1)
  - out_last (output, 1, reset 0)
  - out_keep (output, RATIO in upsize mode, else 1; reset 0)
- Upsize: an accept with in_last=1 closes the word early. Unfilled upper slices are zero, out_keep marks the filled slices (LSB-aligned), and out_last=1.
- Downsize: out_last=1 only on the final slice of a word accepted with in_last=1; out_keep=1.
- When undefined: these ports do not exist, and every word needs exactly RATIO slices.

Decomposition:
- Package bus_width_adapter_pkg holds:
  - function ratio_f(in_w, out_w)
  - function cnt_w_f(ratio)
  - typedef enum for the states (ST_FILL/ST_FULL, ST_IDLE/ST_SEND)
- One sub-module, bus_width_adapter_slice_cnt: the parametrised slice counter with clear/inc/terminal-count flag. It is shared by both modes.
- The top level selects the mode with generate on IN_WIDTH vs OUT_WIDTH.

Test Plan:
- 8->32, out_ready=1, inputs 0x11,0x22,0x33,0x44 on consecutive cycles -> one out word 0x44332211, out_valid high 1 cycle after the 4th accept.
- 32->8, input 0xA1B2C3D4 then 0x01020304 back-to-back, out_ready=1 -> 0xD4,0xC3,0xB2,0xA1,0x04,0x03,0x02,0x01 with no bubble.
- 32->8, out_ready toggled 1,0,0,1,... -> each slice held stable while out_ready=0; in_ready=0 until the final slice transfers.
- 8->32, reset_n pulsed low after 2 accepts (0xAA,0xBB), then 0x01..0x04 -> output 0x04030201 only; out_valid=0 during reset.
- BUS_WIDTH_ADAPTER_LAST_EN, 8->32, inputs 0x11,0x22,0x33 with in_last on 0x33 -> out_data 0x00332211, out_keep=4'b0111, out_last=1.
- 16->16, random valid/ready over 1000 words -> output sequence equals input sequence; in_ready = !out_valid || out_ready.
